axi4_burst_mem_slave: RTL

Synthesizable AXI4 slave memory with full burst support (FIXED, INCR, WRAP) and independent read and write engines. It succeeds the behavioural one-beat slave transfer tasks. It is parametrised in data width, ID width and depth, and drives complete bursts with per-beat responses. It sits behind an interconnect port as the default DUT target for master-side UVM sequences.

---
 rtl/axi4_pkg.sv | 34 +++
 rtl/axi4_burst_mem_slave_if.sv | 58 +++++
 rtl/axi4_addr_gen.sv | 33 +++
 rtl/axi4_burst_mem_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared encodings, FSM state types and helpers for the AXI4 burst memory slave
//
// Purpose : burst/response encodings, write/read FSM state enums and the
//           request-level error test shared by the write and read engines.
// Ports   : none (package).
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  // A request is bad on its own (independent of addresses) when it uses the
  // reserved burst type or a WRAP length that is not 2, 4, 8 or 16 beats.
  function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
    return (burst == BURST_RSVD) ||
           ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

endpackage

// File: rtl/axi4_burst_mem_slave_if.sv
// rtl/axi4_burst_mem_slave_if.sv - AXI4 AW/W/B/AR/R bundle with master and slave modports
//
// Purpose : groups the five AXI4 channels of the burst memory slave.
// Params  : N bytes per beat, I ID width.
// Modports: master drives requests, write data and the B/R ready signals;
//           slave drives the ready signals, B response and R beats.
interface axi4_burst_mem_slave_if #(
  parameter int N = 4,
  parameter int I = 4
);
  logic [I-1:0]   AWID;
  logic [31:0]    AWADDR;
  logic [7:0]     AWLEN;
  logic [1:0]     AWBURST;
  logic           AWVALID;
  logic           AWREADY;

  logic [8*N-1:0] WDATA;
  logic [N-1:0]   WSTRB;
  logic           WLAST;
  logic           WVALID;
  logic           WREADY;

  logic [I-1:0]   BID;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY;

  logic [I-1:0]   ARID;
  logic [31:0]    ARADDR;
  logic [7:0]     ARLEN;
  logic [1:0]     ARBURST;
  logic           ARVALID;
  logic           ARREADY;

  logic [I-1:0]   RID;
  logic [8*N-1:0] RDATA;
  logic [1:0]     RRESP;
  logic           RLAST;
  logic           RVALID;
  logic           RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARBURST, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWBURST, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARID, ARADDR, ARLEN, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/axi4_addr_gen.sv
// rtl/axi4_addr_gen.sv - next-beat byte address for FIXED/INCR/WRAP bursts
//
// Purpose : combinational address step for one burst beat.
// Ports   : addr      in  32  current beat byte address
//           len       in  8   beats minus one
//           burst     in  2   burst type (reserved type steps like INCR)
//           next_addr out 32  byte address of the following beat
module axi4_addr_gen
  import axi4_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] incr;
  logic [31:0] wrap_mask;

  always_comb begin
    incr      = addr + 32'(N);
    // WRAP container is (len+1)*N bytes; the mask keeps the offset inside it
    wrap_mask = ((32'(len) + 32'd1) * 32'(N)) - 32'd1;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// rtl/axi4_burst_mem_slave.sv - AXI4 burst memory slave with independent write and read engines
//
// Purpose : DEPTH x N-byte memory behind a full AXI4 slave port supporting
//           FIXED/INCR/WRAP bursts, per-beat read responses and one B
//           response per write burst.
// Params  : N bytes per beat (power of 2), I ID width, DEPTH words (power of 2).
// Ports   : ACLK    in  clock, rising edge
//           ARESETn in  asynchronous active-low reset
//           bus     slave modport of axi4_burst_mem_slave_if (AW/W/B/AR/R)
module axi4_burst_mem_slave
  import axi4_pkg::*;
#(
  parameter int N     = 4,
  parameter int I     = 4,
  parameter int DEPTH = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axi4_burst_mem_slave_if.slave bus
);

  localparam int L  = $clog2(N);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [8*N-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [31:0] a);
    return (a >> L) < 32'(DEPTH);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'(a >> L);
  endfunction

  // ---------------- write engine ----------------
  wstate_t     wstate;
  logic        awready, wready, bvalid;
  logic [I-1:0] bid;
  logic [1:0]  bresp;
  logic [31:0] waddr, waddr_next;
  logic [7:0]  wlen, wcnt;
  logic [1:0]  wburst;
  logic        werr;
  logic        w_last_beat, w_beat_err, mem_we;

  axi4_addr_gen #(.N(N)) u_waddr_gen (
    .addr      (waddr),
    .len       (wlen),
    .burst     (wburst),
    .next_addr (waddr_next)
  );

  assign w_last_beat = (wcnt == wlen);
  // WLAST must agree with the beat count; the count alone ends the burst
  assign w_beat_err  = !in_range(waddr) || (bus.WLAST != w_last_beat);
  assign mem_we      = (wstate == W_DATA) && bus.WVALID && in_range(waddr);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wstate  <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      waddr   <= '0;
      wlen    <= '0;
      wburst  <= BURST_FIXED;
      wcnt    <= '0;
      werr    <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          awready <= 1'b1;
          if (awready && bus.AWVALID) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            bid     <= bus.AWID;
            waddr   <= bus.AWADDR;
            wlen    <= bus.AWLEN;
            wburst  <= bus.AWBURST;
            wcnt    <= '0;
            werr    <= burst_err(bus.AWBURST, bus.AWLEN);
            wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (bus.WVALID) begin
            waddr <= waddr_next;
            wcnt  <= wcnt + 8'd1;
            if (w_last_beat) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bresp  <= (werr || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              wstate <= W_RESP;
            end else begin
              werr <= werr || w_beat_err;
            end
          end
        end
        W_RESP: begin
          if (bus.BREADY) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Memory array has no reset; out-of-range beats never reach it.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < N; b++) begin
        if (bus.WSTRB[b]) mem[word_idx(waddr)][8*b +: 8] <= bus.WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  rstate_t      rstate;
  logic         arready, rvalid, rlast;
  logic [I-1:0] rid;
  logic [8*N-1:0] rdata;
  logic [1:0]   rresp;
  logic [31:0]  raddr, rsel_addr, raddr_next;
  logic [7:0]   rlen, rsel_len, rcnt;
  logic [1:0]   rburst, rsel_burst;
  logic         rerr;

  // In idle the generator steps the incoming AR address so beat 1's address
  // is ready the moment beat 0 is loaded.
  assign rsel_addr  = (rstate == R_IDLE) ? bus.ARADDR  : raddr;
  assign rsel_len   = (rstate == R_IDLE) ? bus.ARLEN   : rlen;
  assign rsel_burst = (rstate == R_IDLE) ? bus.ARBURST : rburst;

  axi4_addr_gen #(.N(N)) u_raddr_gen (
    .addr      (rsel_addr),
    .len       (rsel_len),
    .burst     (rsel_burst),
    .next_addr (raddr_next)
  );

  // The R register samples mem with a non-blocking read, so a same-cycle
  // write to that word is seen only on a later load (read-before-write).
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      raddr   <= '0;
      rlen    <= '0;
      rburst  <= BURST_FIXED;
      rcnt    <= '0;
      rerr    <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          arready <= 1'b1;
          if (arready && bus.ARVALID) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rid     <= bus.ARID;
            rlen    <= bus.ARLEN;
            rburst  <= bus.ARBURST;
            rerr    <= burst_err(bus.ARBURST, bus.ARLEN);
            rcnt    <= '0;
            rlast   <= (bus.ARLEN == 8'd0);
            rdata   <= in_range(bus.ARADDR) ? mem[word_idx(bus.ARADDR)] : '0;
            rresp   <= (burst_err(bus.ARBURST, bus.ARLEN) || !in_range(bus.ARADDR))
                       ? RESP_SLVERR : RESP_OKAY;
            raddr   <= raddr_next;
            rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.RREADY) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              rstate  <= R_IDLE;
            end else begin
              rcnt  <= rcnt + 8'd1;
              rlast <= ((rcnt + 8'd1) == rlen);
              rdata <= in_range(raddr) ? mem[word_idx(raddr)] : '0;
              rresp <= (rerr || !in_range(raddr)) ? RESP_SLVERR : RESP_OKAY;
              raddr <= raddr_next;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid;
  assign bus.BID     = bid;
  assign bus.BRESP   = bresp;
  assign bus.ARREADY = arready;
  assign bus.RVALID  = rvalid;
  assign bus.RLAST   = rlast;
  assign bus.RID     = rid;
  assign bus.RDATA   = rdata;
  assign bus.RRESP   = rresp;

endmodule
